// File: rtl/fetch_buffer_pkg.sv
// Shared opcode constants, FSM state type and FIFO entry layout for the fetch buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a. The entry carries a predecode bit only when FETCH_PREDECODE_EN is defined.
package fetch_buffer_pkg;

    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_SW    = 6'b101011;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [5:0]  OP_BNE   = 6'b000101;
    localparam logic [5:0]  OP_JRT   = 6'b011110;
    localparam logic [5:0]  OP_ALU   = 6'b000000;
    localparam logic [31:0] NO_OP    = 32'h0;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fb_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
`ifdef FETCH_PREDECODE_EN
        logic        ctrl;
`endif
    } fetch_entry_t;

`ifdef FETCH_PREDECODE_EN
    // True for instructions that can redirect the fetch stream.
    function automatic logic is_ctrl(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JRT);
    endfunction
`endif

endpackage

// File: rtl/fetch_buffer_if.sv
// Bundle of the memory-side, redirect and IF/ID-side signals of the fetch buffer.
// Latency: n/a (wiring only).
// Backpressure: imem_req/imem_gnt on the memory side, inst_valid/inst_ready toward IF/ID; inst_ctrl exists only with FETCH_PREDECODE_EN.
interface fetch_buffer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
`ifdef FETCH_PREDECODE_EN
    logic        inst_ctrl;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_ctrl,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc, inst_ctrl,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
`else
    modport master (
        output imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_out, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );
`endif
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush; head is presented combinationally from storage.
// Latency: a push is visible at o_dout the cycle after it is written.
// Backpressure: none internally; the caller must not push when full. Flush overrides push and pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !i_flush;
    assign w_do_pop  = i_pop && !i_flush && (r_count != '0);

    // Entry storage; contents need no reset because the count gates visibility.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/fetch_buffer.sv
// Prefetching instruction buffer replacing the direct IMemory read ahead of IF/ID (FETCH_PREDECODE_EN adds inst_ctrl).
// Latency: memory response -> inst_valid one cycle later; first request one cycle after reset release.
// Backpressure: inst_ready low holds the head; requests stop when FIFO entries plus in-flight requests reach DEPTH.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    fetch_buffer_if.master bus
);

    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam int          LP_EW    = $bits(fetch_entry_t);
    localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);
    localparam logic [CW:0] LP_MAXO  = (CW + 1)'(MAX_OUTSTANDING);

    fb_state_t     r_state;
    fb_state_t     w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_kill_cnt;

    logic [CW-1:0] w_count;
    logic          w_empty;
    logic          w_full;
    logic [CW:0]   w_fill;
    logic          w_room;
    logic          w_req;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_kill_rsp;
    logic [CW-1:0] w_out_nxt;
    logic [31:0]   w_redirect_pc;
    fetch_entry_t  w_entry;
    fetch_entry_t  w_head;
    logic [LP_EW-1:0] w_head_dat;

    // In-flight requests are counted against FIFO space so a response always has a slot.
    assign w_fill        = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_room        = (w_fill < LP_DEPTH) && ({1'b0, r_outstanding} < LP_MAXO);
    assign w_grant       = w_req && bus.imem_gnt;
    assign w_kill_rsp    = bus.imem_rvalid && (r_kill_cnt != '0);
    assign w_push        = bus.imem_rvalid && (r_kill_cnt == '0) && !bus.redirect_valid;
    assign w_pop         = !w_empty && bus.inst_ready && !bus.redirect_valid;
    assign w_out_nxt     = r_outstanding + CW'(w_grant) - CW'(bus.imem_rvalid);
    assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_BOOT;
        else          r_state <= w_state_nxt;
    end

    // BOOT lasts one cycle with no requests; RUN issues whenever there is room.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  w_req       = w_room;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // Fetch/response PCs and request accounting; redirect overrides grant and push, and
    // every request still in flight after this cycle becomes a response to discard.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_kill_cnt    <= '0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc    <= w_redirect_pc;
            r_resp_pc     <= w_redirect_pc;
            r_outstanding <= w_out_nxt;
            r_kill_cnt    <= w_out_nxt;
        end else begin
            if (w_grant)    r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push)     r_resp_pc  <= r_resp_pc + 32'd4;
            if (w_kill_rsp) r_kill_cnt <= r_kill_cnt - CW'(1);
            r_outstanding <= w_out_nxt;
        end
    end

    // Build the entry written on a live response.
    always_comb begin
        w_entry       = '0;
        w_entry.instr = bus.imem_rdata;
        w_entry.pc    = r_resp_pc;
`ifdef FETCH_PREDECODE_EN
        w_entry.ctrl  = is_ctrl(bus.imem_rdata);
`endif
    end

    fetch_fifo #(
        .WIDTH (LP_EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_din   (w_entry),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .o_dout  (w_head_dat),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    assign w_head = w_head_dat;

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = r_fetch_pc;
    assign bus.inst_valid = !w_empty;
    assign bus.inst_out   = w_empty ? NO_OP : w_head.instr;
    assign bus.inst_pc    = w_empty ? r_resp_pc : w_head.pc;
`ifdef FETCH_PREDECODE_EN
    assign bus.inst_ctrl  = !w_empty && w_head.ctrl;
`endif

    a_no_push_when_full: assert property (@(posedge clock) disable iff (!reset_n) !(w_push && w_full));

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: stimulus queues expected fetch addresses and instructions,
// a negedge monitor pops and compares whenever a grant or an IF/ID consume is presented.
// A small memory model grants immediately and answers after a configurable latency.
module tb_fetch_buffer;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   pops     = 0;
    int   mem_lat  = 1;
    int   snap;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_addr_q[$];

    logic [3:0]  p_vld;
    logic [31:0] p_addr [4];

    always #5 clock = ~clock;

    fetch_buffer_if bus();

    fetch_buffer #(
        .DEPTH           (4),
        .RESET_PC        (32'h0),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Memory image: BNE at 4, BEQ at 0x44, JRT at 0x48, LW elsewhere; low bits carry the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [5:0] op;
        case (a)
            32'h4:   op = 6'b000101;
            32'h44:  op = 6'b000100;
            32'h48:  op = 6'b011110;
            default: op = 6'b100011;
        endcase
        return {op, a[25:0]};
    endfunction

    function automatic logic exp_ctrl(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        return (w[31:26] == 6'b000100) || (w[31:26] == 6'b000101) || (w[31:26] == 6'b011110);
    endfunction

    // Memory model: grant every request, deliver in order after mem_lat cycles.
    assign bus.imem_gnt    = bus.imem_req;
    assign bus.imem_rvalid = p_vld[0];
    assign bus.imem_rdata  = p_vld[0] ? mem_word(p_addr[0]) : 32'hDEAD_BEEF;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            p_vld <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                p_vld[i]  <= p_vld[i+1];
                p_addr[i] <= p_addr[i+1];
            end
            p_vld[3] <= 1'b0;
            if (bus.imem_req && bus.imem_gnt) begin
                p_vld[mem_lat-1]  <= 1'b1;
                p_addr[mem_lat-1] <= bus.imem_addr;
            end
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_empty(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %h but nothing was expected at %0t", name, act, $time);
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        exp_pc_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_pc_q.push_back(start + 32'(4 * i));
            exp_addr_q.push_back(start + 32'(4 * i));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Monitor: compare granted addresses and consumed instructions against the queues.
    always @(negedge clock) begin
        logic [31:0] e;
        if (reset_n && !bus.redirect_valid) begin
            if (bus.imem_req && bus.imem_gnt) begin
                if (exp_addr_q.size() == 0) fail_empty("imem_addr", bus.imem_addr);
                else begin
                    e = exp_addr_q.pop_front();
                    check32("imem_addr", bus.imem_addr, e);
                end
            end
            if (bus.inst_valid && bus.inst_ready) begin
                pops++;
                if (exp_pc_q.size() == 0) fail_empty("inst_pc", bus.inst_pc);
                else begin
                    e = exp_pc_q.pop_front();
                    check32("inst_pc", bus.inst_pc, e);
                    check32("inst_out", bus.inst_out, mem_word(e));
`ifdef FETCH_PREDECODE_EN
                    check32("inst_ctrl", 32'(bus.inst_ctrl), 32'(exp_ctrl(e)));
`endif
                end
            end else if (!bus.inst_valid) begin
                check32("idle_inst_out", bus.inst_out, 32'h0);
`ifdef FETCH_PREDECODE_EN
                check32("idle_inst_ctrl", 32'(bus.inst_ctrl), 32'h0);
`endif
            end
        end
    end

    task automatic do_reset(input logic rdy, input int lat);
        reset_n            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = rdy;
        mem_lat            = lat;
        #1;
        check32("rst_imem_req", 32'(bus.imem_req), 32'h0);
        check32("rst_imem_addr", bus.imem_addr, 32'h0);
        check32("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        check32("rst_inst_out", bus.inst_out, 32'h0);
        check32("rst_inst_pc", bus.inst_pc, 32'h0);
        check32("rst_outstanding", 32'(dut.r_outstanding), 32'h0);
        check32("rst_kill_cnt", 32'(dut.r_kill_cnt), 32'h0);
`ifdef FETCH_PREDECODE_EN
        check32("rst_inst_ctrl", 32'(bus.inst_ctrl), 32'h0);
`endif
        push_stream(32'h0, 40);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        #1;
        check32("boot_no_req", 32'(bus.imem_req), 32'h0);
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b1;

        // Always-ready stream, 1-cycle memory: first valid after the third edge.
        do_reset(1'b1, 1);
        tick(1);
        check32("run_req_edge1", 32'(bus.imem_req), 32'h1);
        check32("valid_edge1", 32'(bus.inst_valid), 32'h0);
        tick(1);
        check32("valid_edge2", 32'(bus.inst_valid), 32'h0);
        tick(1);
        check32("valid_edge3", 32'(bus.inst_valid), 32'h1);
        check32("first_pc", bus.inst_pc, 32'h0);
        snap = pops;
        tick(10);
        check32("stream_pops", 32'(pops - snap), 32'd10);

        // Redirect in steady state (response, pop and grant all present) to an unaligned wrap target.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFB;
        push_stream(32'hFFFF_FFF8, 40);
        tick(1);
        bus.redirect_valid = 1'b0;
        check32("wrap_addr", bus.imem_addr, 32'hFFFF_FFF8);
        check32("wrap_req_next", 32'(bus.imem_req), 32'h1);
        check32("wrap_flushed", 32'(bus.inst_valid), 32'h0);
        check32("wrap_kill_cnt", 32'(dut.r_kill_cnt), 32'h1);
        snap = pops;
        tick(8);
        check32("wrap_pops", 32'(pops - snap), 32'd6);

        // Stalled consumer: FIFO fills with pc 0..C and requests stop.
        do_reset(1'b0, 1);
        tick(14);
        check32("stall_req_low", 32'(bus.imem_req), 32'h0);
        check32("stall_valid", 32'(bus.inst_valid), 32'h1);
        check32("stall_head_pc", bus.inst_pc, 32'h0);
        check32("stall_count", 32'(dut.w_count), 32'd4);
        bus.inst_ready = 1'b1;
        snap = pops;
        tick(4);
        bus.inst_ready = 1'b0;
        check32("release_pops", 32'(pops - snap), 32'd4);
        check32("release_head_pc", bus.inst_pc, 32'h10);

        // Two-cycle memory: redirect to 0x40 while 8 and C are in flight.
        do_reset(1'b1, 2);
        tick(5);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        push_stream(32'h40, 40);
        tick(1);
        bus.redirect_valid = 1'b0;
        check32("redir_addr", bus.imem_addr, 32'h40);
        check32("redir_req_blocked", 32'(bus.imem_req), 32'h0);
        check32("redir_flushed", 32'(bus.inst_valid), 32'h0);
        check32("redir_kill_cnt", 32'(dut.r_kill_cnt), 32'h2);
        for (int i = 0; i < 20 && !bus.inst_valid; i++) tick(1);
        check32("redir_valid_seen", 32'(bus.inst_valid), 32'h1);
        check32("redir_first_pc", bus.inst_pc, 32'h40);
        tick(2);
        check32("burst_outstanding", 32'(dut.r_outstanding), 32'h2);

        // Reset mid-burst, then restart at RESET_PC (BNE at 4).
        do_reset(1'b1, 2);
        snap = pops;
        tick(8);
        check32("restart_pops", 32'(pops - snap), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, first fetch address.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, limit on in-flight imem requests (1..DEPTH).
REQ-004 SHALL have these ports:
- clock, input, 1, sole clock; all state on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- imem_req, output, 1, fetch request valid.
- imem_addr, output, 32, byte address of the request (word-aligned).
- imem_gnt, input, 1, request accepted this cycle.
- imem_rvalid, input, 1, response valid; responses return in order, at least 1 cycle after grant.
- imem_rdata, input, 32, instruction word.
- redirect_valid, input, 1, taken branch or JRT from the pipeline.
- redirect_pc, input, 32, new fetch address.
- inst_ready, input, 1, IF/ID accepts (low while stalled).
- inst_valid, output, 1, head entry valid.
- inst_out, output, 32, head instruction; 32'h0 (no_op) when inst_valid=0.
- inst_pc, output, 32, byte address of inst_out.

Function
REQ-005 SHALL sit upstream of the CPU IF/ID register and replace its direct IMemory[PC>>2] read.
REQ-006 SHALL use FSM states BOOT and RUN; reset enters BOOT; BOOT->RUN after exactly one cycle; no requests issue in BOOT.
REQ-007 In RUN, SHALL assert imem_req when (fifo_count + outstanding) < DEPTH and outstanding < MAX_OUTSTANDING; imem_addr = fetch_pc.
REQ-008 SHALL hold imem_req and imem_addr stable until imem_gnt, unless a redirect occurs.
REQ-009 On req&gnt, fetch_pc SHALL advance by 4 (32-bit wrap, 32'hFFFF_FFFC -> 0) and outstanding SHALL increment.
REQ-010 On imem_rvalid with kill_cnt=0, SHALL push {imem_rdata, pc} into the FIFO; the pc is tracked by a response-pc register advanced by 4 per accepted response.
REQ-011 On imem_rvalid with kill_cnt>0, SHALL discard the data and decrement kill_cnt.
REQ-012 SHALL pop the head when inst_valid & inst_ready; push and pop in the same cycle leave count unchanged.
REQ-013 The bypass path SHALL be registered: a response reaches inst_valid no earlier than the cycle after imem_rvalid.
REQ-014 On redirect_valid, all in the same cycle:
- FIFO flushes.
- fetch_pc and response pc <= redirect_pc.
- kill_cnt <= outstanding after this cycle's grant and minus this cycle's response.
- Any same-cycle pop and response are dropped.
- A same-cycle grant counts toward kill_cnt.
REQ-015 The first request to redirect_pc SHALL issue the cycle after redirect_valid.
REQ-016 Redirect SHALL take priority over push, pop and grant.
REQ-017 Push when full SHALL never occur by construction (REQ-007); a verification assertion SHALL check this.
REQ-018 redirect_pc bits [1:0] SHALL be forced to 0.

Reset
REQ-019 On reset_n low, asynchronously:
- imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=RESET_PC.
- FIFO empty, outstanding=0, kill_cnt=0, fetch_pc=RESET_PC, state BOOT.
REQ-020 Responses arriving while reset is asserted SHALL be ignored; the memory side is also reset.

Configuration
REQ-021 With FETCH_PREDECODE_EN defined, SHALL add output inst_ctrl (1 bit), true when the head opcode [31:26] is BEQ 6'b000100, BNE 6'b000101 or JRT 6'b011110. The bit SHALL be computed at push, stored per entry, and forced to 0 when inst_valid=0.
REQ-022 Without FETCH_PREDECODE_EN, inst_ctrl SHALL be absent and there SHALL be no per-entry storage for it.

Structure
REQ-023 A shared package SHALL hold the opcode constants (LW, SW, BEQ, BNE, JRT, ALUop, NO_OP=32'h0) and the FIFO entry struct {instr, pc, ctrl}.
REQ-024 A single sub-module, fetch_fifo (synchronous FIFO with flush, parameterised width/depth), SHALL hold the entries.

Verification
REQ-025 Reset, then always-ready with 1-cycle memory: imem_addr sequence 0,4,8,...; first inst_valid 3 cycles after reset release; inst_pc increments by 4 each cycle.
REQ-026 Hold inst_ready=0: the FIFO holds 4 entries (pc 0..C), imem_req drops, no over-push. Release: 4 consecutive pops in order.
REQ-027 Redirect to 32'h40 with 2 requests outstanding: both stale responses are discarded; the next inst_pc is 32'h40; no instruction from pc 8 or C ever appears.
REQ-028 Redirect in the same cycle as imem_rvalid and pop: the FIFO is empty next cycle; kill_cnt equals outstanding-1 (plus 1 if a grant occurred).
REQ-029 Wrap: redirect to 32'hFFFF_FFF8: addresses FFF8, FFFC, 0000; inst_pc values match.
REQ-030 Assert reset_n mid-burst with 2 outstanding: outputs reach reset values immediately; after release, fetch restarts at RESET_PC; with FETCH_PREDECODE_EN, a BNE at 32'h4 shows inst_ctrl=1.
